// File: rtl/btn_debounce_pkg.sv
// Shared state encoding and parameter defaults for the button debouncer.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int STABLE_CNT_DEF  = 4;

endpackage

// File: rtl/btn_debounce_sync_sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; the last flop is the only output.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/btn_debounce_sync.sv
// Button debouncer: synchronizer plus stability-qualifying FSM with registered level, edge pulses and busy.
// Optional auto-repeat of rise_pulse while held high is enabled by defining BTN_DEBOUNCE_REPEAT_EN.
//
// state     | meaning
// IDLE_LOW  | accepted level 0, waiting for s=1
// WAIT_HIGH | qualifying a 0->1 candidate
// IDLE_HIGH | accepted level 1, waiting for s=0
// WAIT_LOW  | qualifying a 1->0 candidate
module btn_debounce_sync
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CNT  = STABLE_CNT_DEF,
  parameter int CNT_W       = 16,
  parameter int REPEAT_CNT  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic en,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  generate
    if (SYNC_STAGES < 2 || STABLE_CNT < 2 || REPEAT_CNT < 2 || STABLE_CNT > 2**CNT_W) begin : g_bad_param
      $error("btn_debounce_sync: illegal parameter combination");
    end
  endgenerate

  logic             s;
  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt, busy_nxt;
  logic             rpt_fire;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (!en) begin
      // Abandon any qualification; the accepted level is frozen.
      cnt_nxt = '0;
      if (state == WAIT_HIGH)     state_nxt = IDLE_LOW;
      else if (state == WAIT_LOW) state_nxt = IDLE_HIGH;
    end else begin
      case (state)
        IDLE_LOW: begin
          if (s) begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
    busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CNT) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CNT - 1);

  logic [RPT_W-1:0] rpt, rpt_nxt;

  // Runs only while the high level is being held; any exit restarts the period.
  always_comb begin
    rpt_nxt  = '0;
    rpt_fire = 1'b0;
    if (en && state == IDLE_HIGH && state_nxt == IDLE_HIGH) begin
      if (rpt == RPT_LAST) rpt_fire = 1'b1;
      else                 rpt_nxt  = rpt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rpt <= '0;
    else        rpt <= rpt_nxt;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt | rpt_fire;
      fall_pulse <= fall_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Self-checking bench for btn_debounce_sync: fixed vector table, directed corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_btn_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int RPT    = 8;

  logic clk = 1'b0;
  logic rst_n, btn_in, en;
  logic level_out, rise_pulse, fall_pulse, busy;

  int checks = 0;
  int passes = 0;

  btn_debounce_sync #(
    .SYNC_STAGES (SYNC),
    .STABLE_CNT  (STABLE),
    .CNT_W       (16),
    .REPEAT_CNT  (RPT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .en         (en),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: s is btn delayed SYNC edges; a new level is accepted once s has
  // disagreed with the level on STABLE+1 consecutive enabled edges.
  bit m_hist[SYNC];
  int m_run;
  int m_rep;
  bit m_level, m_rise, m_fall, m_busy;

  task automatic model_edge(input bit r, input bit e, input bit b);
    bit s_old;
    bit accepted;
    if (!r) begin
      foreach (m_hist[i]) m_hist[i] = 1'b0;
      m_run = 0; m_rep = 0;
      m_level = 0; m_rise = 0; m_fall = 0; m_busy = 0;
    end else begin
      s_old = m_hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = b;
      m_rise = 0; m_fall = 0; accepted = 0;
      if (!e)                  m_run = 0;
      else if (s_old != m_level) m_run++;
      else                     m_run = 0;
      if (m_run == STABLE + 1) begin
        m_level = s_old; m_rise = s_old; m_fall = !s_old;
        m_run = 0; accepted = 1;
      end
      m_busy = (m_run > 0);
`ifdef BTN_DEBOUNCE_REPEAT_EN
      if (m_level && e && !accepted && m_run == 0) begin
        m_rep++;
        if (m_rep == RPT) begin m_rise = 1; m_rep = 0; end
      end else begin
        m_rep = 0;
      end
`endif
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic e, input logic b);
    rst_n = r; en = e; btn_in = b;
    @(posedge clk);
    model_edge(r, e, b);
    #1;
  endtask

  typedef struct {
    logic r, e, b;
    logic lv, ri, fa, bu;
  } vec_t;

  vec_t tbl[19];
  int   rise_idx[$];

  initial begin
    // Reset with button held, release, accept high, then release button and accept low.
    for (int i = 0; i < 3; i++)   tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 5; i < 9; i++)   tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 13; i < 17; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    rst_n = 1'b0; en = 1'b1; btn_in = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].b);
      chk($sformatf("tbl%0d level", i), level_out,  tbl[i].lv);
      chk($sformatf("tbl%0d rise", i),  rise_pulse, tbl[i].ri);
      chk($sformatf("tbl%0d fall", i),  fall_pulse, tbl[i].fa);
      chk($sformatf("tbl%0d busy", i),  busy,       tbl[i].bu);
    end

    // Bounce: three cycles high then low is rejected with no pulse.
    begin
      logic exp_busy[8];
      exp_busy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
        step(1'b1, 1'b1, (i < 3) ? 1'b1 : 1'b0);
        chk($sformatf("bounce%0d level", i), level_out, 1'b0);
        chk($sformatf("bounce%0d rise", i),  rise_pulse, 1'b0);
        chk($sformatf("bounce%0d busy", i),  busy, exp_busy[i]);
      end
    end

    // Reset during WAIT_HIGH aborts with no pulse.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    chk("pre_rst busy", busy, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("mid_rst busy", busy, 1'b0);
    chk("mid_rst rise", rise_pulse, 1'b0);
    chk("mid_rst level", level_out, 1'b0);

    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        step(1'b1, 1'b1, 1'b1);
        if (level_out) got = 1;
      end
      chk("reach_high timeout", got, 1'b1);
    end
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);

    // en=0 during WAIT_LOW returns to IDLE_HIGH; re-enable restarts the count from zero.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("wait_low busy", busy, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("en_off busy", busy, 1'b0);
    chk("en_off level", level_out, 1'b1);
    chk("en_off fall", fall_pulse, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("en_hold level", level_out, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("en_restart early level", level_out, 1'b1);
    chk("en_restart early fall", fall_pulse, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("en_restart fall", fall_pulse, 1'b1);
    chk("en_restart level", level_out, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);

    // Long hold: count rise pulses over 36 edges.
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (rise_pulse) rise_idx.push_back(i);
    end
`ifdef BTN_DEBOUNCE_REPEAT_EN
    chk("hold rise count is 4", rise_idx.size() == 4, 1'b1);
    if (rise_idx.size() == 4) begin
      chk("hold rise0", rise_idx[0] == 6,  1'b1);
      chk("hold rise1", rise_idx[1] == 14, 1'b1);
      chk("hold rise2", rise_idx[2] == 22, 1'b1);
      chk("hold rise3", rise_idx[3] == 30, 1'b1);
    end
`else
    chk("hold rise count is 1", rise_idx.size() == 1, 1'b1);
    if (rise_idx.size() == 1) chk("hold rise0", rise_idx[0] == 6, 1'b1);
`endif

    // Randomized phase against the reference model.
    begin
      logic b = 1'b1;
      int   hold = 0;
      logic e, r;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          b    = ~b;
          hold = $urandom_range(1, 12);
        end
        hold--;
        e = ($urandom_range(0, 19) != 0);
        r = ($urandom_range(0, 199) != 0);
        step(r, e, b);
        chk("rnd level", level_out,  m_level);
        chk("rnd rise",  rise_pulse, m_rise);
        chk("rnd fall",  fall_pulse, m_fall);
        chk("rnd busy",  busy,       m_busy);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce_sync.md
Name: btn_debounce_sync

Overview:
- Conditions a raw, asynchronous, bouncing push-button or switch input into a clean, clock-synchronous level.
- Feeds the D input of the flip-flop stages (dff/rsff) directly downstream.
- Also produces single-cycle edge pulses and a busy flag for lab counters and shift registers built from those flip-flops.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on btn_in; minimum 2.
- STABLE_CNT, 4: consecutive stable synchronized samples required to accept a new level; minimum 2.
- CNT_W, 16: stability counter width; must satisfy STABLE_CNT <= 2**CNT_W.
- REPEAT_CNT, 8: auto-repeat period in cycles; used only with the optional feature; minimum 2.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- btn_in, input, 1: raw asynchronous button level; may bounce.
- en, input, 1: debounce enable; 0 freezes the accepted level.
- level_out, output, 1: debounced level; drives the downstream flip-flop D input.
- rise_pulse, output, 1: one-cycle pulse on each accepted 0->1 transition.
- fall_pulse, output, 1: one-cycle pulse on each accepted 1->0 transition.
- busy, output, 1: high while a candidate transition is being qualified.

Behaviour:
- Clock and reset (decided): one clock, clk; reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: all synchronizer flops 0, state IDLE_LOW, counter 0, level_out 0, rise_pulse 0, fall_pulse 0, busy 0. Reset overrides every other input, including en.
- Synchronizer: btn_in passes through SYNC_STAGES flops; the last flop is s. btn_in is never used combinationally.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All outputs are registered.
- IDLE_LOW:
  - s=1 -> WAIT_HIGH, counter cleared to 0.
  - Otherwise stay.
- WAIT_HIGH:
  - s=0 -> IDLE_LOW, counter cleared; the glitch is rejected and no pulse is emitted.
  - Else if counter == STABLE_CNT-1 -> IDLE_HIGH, level_out<=1, rise_pulse<=1.
  - Else counter increments.
- IDLE_HIGH and WAIT_LOW: mirror images of the above with inverted sense; the accepting transition sets level_out<=0 and fall_pulse<=1.
- Latency: if btn_in is stable before edge j, level_out and the pulse update at edge j+SYNC_STAGES+STABLE_CNT. With defaults this is 6 edges.
- Pulses: high for exactly one cycle, at the same edge where level_out changes. rise_pulse and fall_pulse are never both high.
- busy = 1 exactly in WAIT_HIGH or WAIT_LOW.
- en=0:
  - The synchronizer keeps running.
  - A WAIT_* state returns to the IDLE_* state that matches level_out, and the counter clears.
  - No pulses are emitted and level_out holds.
  - When en returns to 1, qualification restarts from the count of 0.
- Counter never wraps; it saturates by construction because it is bounded at STABLE_CNT-1.
- Reset asserted mid-qualification aborts it with no pulse.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Defined:
  - A repeat counter of width $clog2(REPEAT_CNT)+1 runs while in IDLE_HIGH with en=1.
  - rise_pulse re-asserts for one cycle every REPEAT_CNT cycles after the accepting edge, for as long as the level holds.
  - The counter clears on leaving IDLE_HIGH, on en=0, and on reset.
- Undefined: exactly one rise_pulse per accepted press; no repeat counter logic is synthesized.

Decomposition:
- Package btn_debounce_pkg holds:
  - the FSM state typedef: 2-bit enum IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3;
  - localparam defaults for SYNC_STAGES and STABLE_CNT.
- One sub-module, sync_chain: parameterized SYNC_STAGES flop synchronizer with synchronous active-low reset, instantiated once.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CNT=4, REPEAT_CNT=8.
1. Hold rst_n=0 for 3 cycles with btn_in=1, then release -> all outputs 0 during reset; level_out=1 and a single rise_pulse at the 6th edge after release.
2. btn_in 0->1, held for 20 cycles -> busy high for 4 cycles, then level_out=1 together with a one-cycle rise_pulse 6 edges after the input change; no fall_pulse.
3. btn_in high for 3 cycles, then low (bounce) -> level_out stays 0, no pulses, busy drops after s returns to 0.
4. From accepted high, btn_in 1->0 held -> fall_pulse for one cycle and level_out=0 after 6 edges.
5. Assert rst_n=0 while busy in WAIT_HIGH -> next edge gives IDLE_LOW, busy=0, no rise_pulse. Separately, pull en=0 during WAIT_LOW -> return to IDLE_HIGH, level_out stays 1.
6. With BTN_DEBOUNCE_REPEAT_EN defined, hold btn_in=1 for 30 cycles -> rise_pulse at the accepting edge, then at +8, +16 and +24 edges. Without the macro -> exactly one rise_pulse.
